// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, redirect input and decode handshake.
// master = fetch unit, slave = memory/execute/decode side.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited req/gnt/rvalid issue, in-order prefetch FIFO.
// Define FETCH_BYPASS_EN for a zero-latency rdata -> decode path when the FIFO is empty.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  typedef logic [PtrW:0] cnt_t;
  typedef enum logic [0:0] {StRun, StDrain} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] pc_q, pc_d;
  cnt_t        out_q, out_d;
  cnt_t        disc_q, disc_d;
  cnt_t        fwp_q, fwp_d, frp_q, frp_d;
  cnt_t        qwp_q, qwp_d, qrp_q, qrp_d;

  logic [31:0] fifo_pc_q    [FIFO_DEPTH];
  logic [31:0] fifo_instr_q [FIFO_DEPTH];
  logic [31:0] inflight_q   [FIFO_DEPTH];

  logic          fire, rv, bypass, push, pop, fifo_empty, credit_ok;
  logic [31:0]   rpc, redir_pc, pc_base;
  cnt_t          fifo_cnt, fifo_cnt_d;
  logic [PtrW+1:0] credit_sum;

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;

  always_comb begin
    redir_pc   = bus.redirect_pc & 32'hFFFF_FFFC;
    fire       = req_q & bus.imem_gnt;
    rv         = bus.imem_rvalid & (out_q != '0);
    rpc        = inflight_q[qrp_q[PtrW-1:0]];
    fifo_cnt   = fwp_q - frp_q;
    fifo_empty = (fifo_cnt == '0);
`ifdef FETCH_BYPASS_EN
    bypass     = fifo_empty & (disc_q == '0) & rv;
`else
    bypass     = 1'b0;
`endif

    if (bypass) begin
      bus.id_valid = ~bus.redirect_valid;
      bus.id_instr = bus.imem_rdata;
      bus.id_pc    = rpc;
    end else if (fifo_empty) begin
      bus.id_valid = 1'b0;
      bus.id_instr = NopInstr;
      bus.id_pc    = pc_q;
    end else begin
      bus.id_valid = 1'b1;
      bus.id_instr = fifo_instr_q[frp_q[PtrW-1:0]];
      bus.id_pc    = fifo_pc_q[frp_q[PtrW-1:0]];
    end

    // A redirect voids the decode handshake and drops any word arriving this cycle.
    pop  = ~bus.redirect_valid & ~fifo_empty & bus.id_ready;
    push = ~bus.redirect_valid & rv & (disc_q == '0) & ~(bypass & bus.id_ready);

    if (bus.redirect_valid) begin
      fwp_d = '0;
      frp_d = '0;
    end else begin
      fwp_d = fwp_q + cnt_t'(push);
      frp_d = frp_q + cnt_t'(pop);
    end
    fifo_cnt_d = fwp_d - frp_d;

    qwp_d = qwp_q + cnt_t'(fire);
    qrp_d = qrp_q + cnt_t'(rv);
    out_d = out_q + cnt_t'(fire) - cnt_t'(rv);

    // A request still waiting for gnt will return a stale word, so it is counted too.
    if (bus.redirect_valid) begin
      disc_d = out_d + cnt_t'(req_q & ~bus.imem_gnt);
    end else if (rv && (disc_q != '0)) begin
      disc_d = disc_q - cnt_t'(1);
    end else begin
      disc_d = disc_q;
    end

    state_d = state_q;
    if (bus.redirect_valid) begin
      state_d = (disc_d != '0) ? StDrain : StRun;
    end else if ((state_q == StDrain) && (disc_d == '0)) begin
      state_d = StRun;
    end

    credit_sum = {1'b0, out_d} + {1'b0, fifo_cnt_d};
    credit_ok  = credit_sum < (PtrW + 2)'(FIFO_DEPTH);
    pc_base    = bus.redirect_valid ? redir_pc : pc_q;

    if (req_q && !bus.imem_gnt) begin
      req_d  = 1'b1;
      addr_d = addr_q;
      pc_d   = pc_base;
    end else if ((state_d == StRun) && credit_ok) begin
      req_d  = 1'b1;
      addr_d = pc_base;
      pc_d   = pc_base + 32'd4;
    end else begin
      req_d  = 1'b0;
      addr_d = pc_base;
      pc_d   = pc_base;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      disc_q  <= '0;
      fwp_q   <= '0;
      frp_q   <= '0;
      qwp_q   <= '0;
      qrp_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      fwp_q   <= fwp_d;
      frp_q   <= frp_d;
      qwp_q   <= qwp_d;
      qrp_q   <= qrp_d;
    end
  end

  // Storage needs no reset: pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (fire) begin
      inflight_q[qwp_q[PtrW-1:0]] <= addr_q;
    end
    if (push) begin
      fifo_pc_q[fwp_q[PtrW-1:0]]    <= rpc;
      fifo_instr_q[fwp_q[PtrW-1:0]] <= bus.imem_rdata;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model plus a PC-stream scoreboard.
module tb_fetch_unit;
  localparam logic [31:0] RstPc = 32'h0000_0000;
  localparam int          Depth = 2;
`ifdef FETCH_BYPASS_EN
  localparam int ExpLat = 0;
`else
  localparam int ExpLat = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RstPc), .FIFO_DEPTH(Depth)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] rpc; logic [31:0] e0; logic [31:0] e1; } rvec_t;

  mreq_t       mq[$];
  int          checks = 0, errors = 0, cyc = 0, n_hs = 0, n_gnt = 0;
  int          gnt_mode, rdy_mode, lat_min, lat_max;
  bit          auto_redir, spurious;
  logic        redir_req;
  logic [31:0] redir_val, exp_pc, prev_addr;
  logic        prev_hold;
  logic        o_gnt, o_rv, o_hs, o_redir, o_idv, o_req;
  logic [31:0] o_addr, o_hspc;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    int lat;
    @(negedge clk);
    bus.imem_gnt = (gnt_mode == 0) ? 1'b1 : (gnt_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    if (mq.size() > 0 && mq[0].due <= cyc && (lat_min == lat_max || $urandom_range(0, 3) != 0))
    begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(mq[0].addr);
    end else begin
      bus.imem_rvalid = spurious && (mq.size() == 0);
      bus.imem_rdata  = $urandom;
    end
    bus.id_ready       = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    bus.redirect_valid = redir_req;
    bus.redirect_pc    = redir_val;
    redir_req          = 1'b0;
    #1;
    if (auto_redir && bus.imem_req && bus.imem_gnt && bus.imem_rvalid) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0200;
      auto_redir         = 1'b0;
    end
    #1;
    if (prev_hold) begin
      check("hold_req", 32'(bus.imem_req), 32'd1);
      check("hold_addr", bus.imem_addr, prev_addr);
    end
    o_req   = bus.imem_req;
    o_addr  = bus.imem_addr;
    o_gnt   = bus.imem_req & bus.imem_gnt;
    o_rv    = bus.imem_rvalid & (mq.size() > 0);
    o_redir = bus.redirect_valid;
    o_idv   = bus.id_valid;
    o_hs    = bus.id_valid & bus.id_ready & ~bus.redirect_valid;
    if (o_hs) begin
      check("id_pc", bus.id_pc, exp_pc);
      check("id_instr", bus.id_instr, mem_word(exp_pc));
      o_hspc = bus.id_pc;
      exp_pc += 32'd4;
      n_hs++;
    end
    if (o_redir) exp_pc = bus.redirect_pc & 32'hFFFF_FFFC;
    if (o_gnt) n_gnt++;
    prev_hold = bus.imem_req & ~bus.imem_gnt;
    prev_addr = bus.imem_addr;
    @(posedge clk);
    cyc++;
    if (o_rv) mq.delete(0);
    if (o_gnt) begin
      lat = $urandom_range(lat_min, lat_max);
      mq.push_back('{addr: o_addr, due: cyc + lat - 1});
    end
    checks++;
    if (mq.size() > Depth) begin
      errors++;
      $display("FAIL outstanding: got %0d allowed %0d", mq.size(), Depth);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n              = 1'b0;
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    mq.delete();
    prev_hold  = 1'b0;
    exp_pc     = RstPc;
    redir_req  = 1'b0;
    auto_redir = 1'b0;
    spurious   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rvec_t       vecs[4];
    logic [31:0] ga[$];
    int          t_rv, t_id, h0, g0, g, got;
    logic [31:0] p0, p1;
    bit          found;

    vecs[0] = '{rpc: 32'h0000_0103, e0: 32'h0000_0100, e1: 32'h0000_0104};
    vecs[1] = '{rpc: 32'hFFFF_FFFE, e0: 32'hFFFF_FFFC, e1: 32'h0000_0000};
    vecs[2] = '{rpc: 32'h1000_0001, e0: 32'h1000_0000, e1: 32'h1000_0004};
    vecs[3] = '{rpc: 32'h0000_0040, e0: 32'h0000_0040, e1: 32'h0000_0044};

    gnt_mode = 0; rdy_mode = 0; lat_min = 1; lat_max = 1;
    redir_val = '0;

    // Reset values
    do_reset();
    @(negedge clk); rst_n = 1'b0; #1;
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_addr", bus.imem_addr, RstPc);
    check("rst_idv", 32'(bus.id_valid), 32'd0);
    check("rst_instr", bus.id_instr, 32'h0000_0013);
    check("rst_pc", bus.id_pc, RstPc);

    // Streaming fetch, latency and address sequence
    do_reset();
    t_rv = -1; t_id = -1; h0 = n_hs;
    for (int i = 0; i < 12; i++) begin
      step();
      if (o_rv && t_rv < 0) t_rv = i;
      if (o_idv && t_id < 0) t_id = i;
      if (o_gnt) ga.push_back(o_addr);
    end
    check("t1_latency", 32'(t_id - t_rv), 32'(ExpLat));
    check("t1_ngnt", 32'(ga.size() >= 4), 32'd1);
    for (int k = 0; k < 4; k++) if (k < ga.size()) check("t1_addr", ga[k], 32'(k * 4));
    check("t1_progress", 32'(n_hs - h0 >= 4), 32'd1);

    // Decode stall: credit limit, then in-order drain
    do_reset();
    rdy_mode = 1; g0 = n_gnt;
    repeat (10) step();
    check("t2_ngnt", 32'(n_gnt - g0), 32'(Depth));
    check("t2_req_low", 32'(o_req), 32'd0);
    check("t2_idv", 32'(o_idv), 32'd1);
    rdy_mode = 0; h0 = n_hs;
    repeat (20) step();
    check("t2_drain", 32'(n_hs - h0 >= 4), 32'd1);

    // Redirect with two requests outstanding
    do_reset();
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 20 && mq.size() != Depth; i++) step();
    check("t3_two_out", 32'(mq.size()), 32'(Depth));
    redir_req = 1'b1; redir_val = 32'h0000_0103;
    step();
    ga.delete(); found = 1'b0;
    for (int i = 0; i < 40 && !(found && ga.size() > 0); i++) begin
      step();
      if (o_gnt) ga.push_back(o_addr);
      if (o_hs && !found) begin found = 1'b1; p0 = o_hspc; end
    end
    check("t3_addr", (ga.size() > 0) ? ga[0] : 32'hDEAD_BEEF, 32'h0000_0100);
    check("t3_pc", found ? p0 : 32'hDEAD_BEEF, 32'h0000_0100);

    // Redirect while a request waits for gnt
    do_reset();
    lat_min = 1; lat_max = 1; gnt_mode = 1;
    for (int i = 0; i < 10 && !o_req; i++) step();
    repeat (2) step();
    redir_req = 1'b1; redir_val = 32'h0000_0100;
    step();
    repeat (2) step();
    check("t4_req_held", 32'(o_req), 32'd1);
    check("t4_addr_held", o_addr, RstPc);
    gnt_mode = 0; ga.delete(); found = 1'b0;
    for (int i = 0; i < 30 && !(found && ga.size() >= 2); i++) begin
      step();
      if (o_gnt) ga.push_back(o_addr);
      if (o_hs && !found) begin found = 1'b1; p0 = o_hspc; end
    end
    check("t4_stale_addr", (ga.size() > 0) ? ga[0] : 32'hDEAD_BEEF, RstPc);
    check("t4_new_addr", (ga.size() > 1) ? ga[1] : 32'hDEAD_BEEF, 32'h0000_0100);
    check("t4_pc", found ? p0 : 32'hDEAD_BEEF, 32'h0000_0100);

    // Redirect coincident with gnt and rvalid
    do_reset();
    auto_redir = 1'b1;
    for (int i = 0; i < 10 && !o_redir; i++) step();
    check("t5_hit", 32'(o_redir), 32'd1);
    check("t5_discard", 32'(mq.size()), 32'd1);
    g = 0;
    for (int i = 0; i < 10 && mq.size() > 0; i++) begin
      step();
      if (o_gnt) g++;
    end
    check("t5_drain_noissue", 32'(g), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (o_hs) begin found = 1'b1; p0 = o_hspc; end
    end
    check("t5_pc", found ? p0 : 32'hDEAD_BEEF, 32'h0000_0200);

    // rvalid with nothing outstanding is ignored
    do_reset();
    gnt_mode = 1; spurious = 1'b1; h0 = n_hs;
    repeat (5) step();
    check("misuse_no_id", 32'(n_hs - h0), 32'd0);
    spurious = 1'b0; gnt_mode = 0;
    repeat (10) step();
    check("misuse_recover", 32'(n_hs - h0 >= 3), 32'd1);

    // Asynchronous reset with the FIFO full, then restart
    do_reset();
    rdy_mode = 1;
    repeat (10) step();
    check("t6_full", 32'(o_idv), 32'd1);
    @(negedge clk); #2;
    bus.imem_rvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_req", 32'(bus.imem_req), 32'd0);
    check("t6_addr", bus.imem_addr, RstPc);
    check("t6_idv", 32'(bus.id_valid), 32'd0);
    check("t6_instr", bus.id_instr, 32'h0000_0013);
    check("t6_pc", bus.id_pc, RstPc);
    do_reset();
    rdy_mode = 0; ga.delete(); h0 = n_hs;
    for (int i = 0; i < 12; i++) begin
      step();
      if (o_gnt) ga.push_back(o_addr);
    end
    check("t6_restart", (ga.size() > 0) ? ga[0] : 32'hDEAD_BEEF, RstPc);
    check("t6_progress", 32'(n_hs - h0 >= 4), 32'd1);

    // Table of redirect targets under random grant/latency
    do_reset();
    gnt_mode = 2; lat_min = 1; lat_max = 3;
    foreach (vecs[v]) begin
      repeat (3) step();
      redir_req = 1'b1; redir_val = vecs[v].rpc;
      step();
      got = 0; p0 = 32'hDEAD_BEEF; p1 = 32'hDEAD_BEEF;
      for (int i = 0; i < 60 && got < 2; i++) begin
        step();
        if (o_hs) begin
          if (got == 0) p0 = o_hspc; else p1 = o_hspc;
          got++;
        end
      end
      check("vec_pc0", p0, vecs[v].e0);
      check("vec_pc1", p1, vecs[v].e1);
    end

    // Random traffic against the scoreboard
    rdy_mode = 2; lat_max = 4; h0 = n_hs;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 4) begin
        redir_req = 1'b1;
        redir_val = $urandom;
      end
      step();
    end
    check("rand_progress", 32'(n_hs - h0 > 100), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
